// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline scoreboard slice.
//   - opcode constants used by the core's decode and by benches
//   - slot record layout at the default core widths (32-bit data, 2-bit encodings)
//   - operand source encoding: FWD_RF selects the register file, k+1 selects slot k
package pipe_pkg;

  localparam logic [2:0] NOP = 3'b000;
  localparam logic [2:0] ADD = 3'b001;
  localparam logic [2:0] INC = 3'b011;

  localparam int FWD_RF = 0;

  localparam int SLOT_DATA_W = 32;
  localparam int SLOT_ENC_W  = 2;

  // One in-flight register write. rdy means data already holds the final result.
  typedef struct packed {
    logic                   valid;
    logic [SLOT_ENC_W-1:0]  rd;
    logic                   late;
    logic                   rdy;
    logic [SLOT_DATA_W-1:0] data;
  } slot_t;

endpackage

// File: rtl/sb_operand_lookup.sv
// Youngest-match operand resolver for one source register.
// Ports:
//   use_i        source is actually read
//   rs_i         source register encoding
//   valid_i/late_i/rdy_i/rd_i/data_i  flattened slot fields, slot 0 = EX
//   rf_val_i     register-file read data
//   ex_result_i  combinational result of the slot-0 instruction
//   mem_result_i combinational result of the slot-1 instruction
//   op_val_o     resolved operand
//   fwd_src_o    FWD_RF, or k+1 when slot k supplies the value
//   hazard_o     value cannot be supplied this cycle
module sb_operand_lookup
  import pipe_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int ENC_W      = 2,
  parameter int PIPE_DEPTH = 3,
  parameter int FWD_EN     = 1,
  parameter int SRC_W      = 2
) (
  input  logic                        use_i,
  input  logic [ENC_W-1:0]            rs_i,
  input  logic [PIPE_DEPTH-1:0]       valid_i,
  input  logic [PIPE_DEPTH-1:0]       late_i,
  input  logic [PIPE_DEPTH-1:0]       rdy_i,
  input  logic [PIPE_DEPTH*ENC_W-1:0] rd_i,
  input  logic [PIPE_DEPTH*DATA_W-1:0] data_i,
  input  logic [DATA_W-1:0]           rf_val_i,
  input  logic [DATA_W-1:0]           ex_result_i,
  input  logic [DATA_W-1:0]           mem_result_i,
  output logic [DATA_W-1:0]           op_val_o,
  output logic [SRC_W-1:0]            fwd_src_o,
  output logic                        hazard_o
);

  logic              found;
  int                hit_idx;
  logic              hit_late;
  logic              hit_rdy;
  logic [DATA_W-1:0] hit_data;

  // Scan oldest to youngest so the last hit written is the youngest match.
  always_comb begin
    found    = 1'b0;
    hit_idx  = 0;
    hit_late = 1'b0;
    hit_rdy  = 1'b0;
    hit_data = '0;
    for (int k = PIPE_DEPTH - 1; k >= 0; k--) begin
      if (valid_i[k] && (rd_i[k*ENC_W +: ENC_W] == rs_i)) begin
        found    = 1'b1;
        hit_idx  = k;
        hit_late = late_i[k];
        hit_rdy  = rdy_i[k];
        hit_data = data_i[k*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    op_val_o  = rf_val_i;
    fwd_src_o = SRC_W'(FWD_RF);
    hazard_o  = 1'b0;
    if (use_i && found) begin
      if (FWD_EN == 0) begin
        // Legacy mode: wait until the write has left the tracked slots.
        hazard_o = 1'b1;
      end else begin
        fwd_src_o = SRC_W'(hit_idx + 1);
        if (hit_idx == 0) begin
          // A late result does not exist until MEM.
          op_val_o = ex_result_i;
          hazard_o = hit_late;
        end else if (hit_idx == 1 && hit_late && !hit_rdy) begin
          op_val_o = mem_result_i;
        end else begin
          op_val_o = hit_data;
        end
      end
    end
  end

endmodule

// File: rtl/pipe_scoreboard.sv
// Hazard, forwarding and writeback tracker for the pipelined core.
// Every in-flight register write occupies one slot of a PIPE_DEPTH-deep shift
// structure (slot 0 = EX, slot 1 = MEM, slot PIPE_DEPTH-1 = WB). Operands for
// the ID/EX boundary are resolved from the youngest matching slot; stall is
// raised only when the value does not exist yet. While stall=1 the IF/ID stage
// holds and ID/EX latches a bubble; the scoreboard itself never tracks a
// stalled instruction.
// Ports:
//   clk, resetn                     clock, asynchronous active-low reset
//   flush                           kill the ID instruction and the EX slot
//   id_*                            decoded ID-stage instruction
//   rf_val1, rf_val2                register-file read data
//   ex_result, mem_result           EX (slot 0) and MEM (slot 1) results
//   stall                           hold IF/ID, bubble into EX
//   op_val1/2, fwd_src1/2           resolved operands and their source
//   busy_vec                        registers with a pending write
//   wb_we, wb_rd, wb_data           register-file write port
module pipe_scoreboard
  import pipe_pkg::*;
#(
  parameter  int DATA_W     = 32,
  parameter  int NUM_REGS   = 4,
  parameter  int ENC_W      = 2,
  parameter  int PIPE_DEPTH = 3,
  parameter  int FWD_EN     = 1,
  localparam int SRC_W      = $clog2(PIPE_DEPTH + 1)
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                flush,
  input  logic                id_valid,
  input  logic [ENC_W-1:0]    id_rs1,
  input  logic [ENC_W-1:0]    id_rs2,
  input  logic                id_use_rs1,
  input  logic                id_use_rs2,
  input  logic [ENC_W-1:0]    id_rd,
  input  logic                id_we,
  input  logic                id_late,
  input  logic [DATA_W-1:0]   rf_val1,
  input  logic [DATA_W-1:0]   rf_val2,
  input  logic [DATA_W-1:0]   ex_result,
  input  logic [DATA_W-1:0]   mem_result,
  output logic                stall,
  output logic [DATA_W-1:0]   op_val1,
  output logic [DATA_W-1:0]   op_val2,
  output logic [SRC_W-1:0]    fwd_src1,
  output logic [SRC_W-1:0]    fwd_src2,
  output logic [NUM_REGS-1:0] busy_vec,
  output logic                wb_we,
  output logic [ENC_W-1:0]    wb_rd,
  output logic [DATA_W-1:0]   wb_data
);

  typedef struct packed {
    logic              valid;
    logic [ENC_W-1:0]  rd;
    logic              late;
    logic              rdy;
    logic [DATA_W-1:0] data;
  } trk_slot_t;

  trk_slot_t slot_q [PIPE_DEPTH];
  trk_slot_t slot_d [PIPE_DEPTH];

  logic              wb_we_q;
  logic [ENC_W-1:0]  wb_rd_q;
  logic [DATA_W-1:0] wb_data_q;

  logic hazard1, hazard2;

  // Flattened slot view for the two lookup instances.
  logic [PIPE_DEPTH-1:0]        s_valid, s_late, s_rdy;
  logic [PIPE_DEPTH*ENC_W-1:0]  s_rd;
  logic [PIPE_DEPTH*DATA_W-1:0] s_data;

  always_comb begin
    s_valid = '0;
    s_late  = '0;
    s_rdy   = '0;
    s_rd    = '0;
    s_data  = '0;
    for (int k = 0; k < PIPE_DEPTH; k++) begin
      s_valid[k]                 = slot_q[k].valid;
      s_late[k]                  = slot_q[k].late;
      s_rdy[k]                   = slot_q[k].rdy;
      s_rd[k*ENC_W +: ENC_W]     = slot_q[k].rd;
      s_data[k*DATA_W +: DATA_W] = slot_q[k].data;
    end
  end

  sb_operand_lookup #(
    .DATA_W(DATA_W), .ENC_W(ENC_W), .PIPE_DEPTH(PIPE_DEPTH),
    .FWD_EN(FWD_EN), .SRC_W(SRC_W)
  ) u_lookup_rs1 (
    .use_i(id_use_rs1), .rs_i(id_rs1),
    .valid_i(s_valid), .late_i(s_late), .rdy_i(s_rdy), .rd_i(s_rd), .data_i(s_data),
    .rf_val_i(rf_val1), .ex_result_i(ex_result), .mem_result_i(mem_result),
    .op_val_o(op_val1), .fwd_src_o(fwd_src1), .hazard_o(hazard1)
  );

  sb_operand_lookup #(
    .DATA_W(DATA_W), .ENC_W(ENC_W), .PIPE_DEPTH(PIPE_DEPTH),
    .FWD_EN(FWD_EN), .SRC_W(SRC_W)
  ) u_lookup_rs2 (
    .use_i(id_use_rs2), .rs_i(id_rs2),
    .valid_i(s_valid), .late_i(s_late), .rdy_i(s_rdy), .rd_i(s_rd), .data_i(s_data),
    .rf_val_i(rf_val2), .ex_result_i(ex_result), .mem_result_i(mem_result),
    .op_val_o(op_val2), .fwd_src_o(fwd_src2), .hazard_o(hazard2)
  );

  // flush wins over stall.
  assign stall = id_valid & ~flush & (hazard1 | hazard2);

  always_comb begin
    slot_d = slot_q;

    slot_d[0].valid = id_valid & id_we & ~stall & ~flush;
    slot_d[0].rd    = id_rd;
    slot_d[0].late  = id_late;
    slot_d[0].rdy   = 1'b0;
    slot_d[0].data  = '0;

    // EX -> MEM: capture the ALU result; a late entry still waits for MEM.
    // A flushed EX entry is dropped here and never reaches MEM.
    slot_d[1]       = slot_q[0];
    slot_d[1].valid = slot_q[0].valid & ~flush;
    slot_d[1].rdy   = ~slot_q[0].late;
    slot_d[1].data  = ex_result;

    for (int k = 2; k < PIPE_DEPTH; k++) begin
      slot_d[k] = slot_q[k-1];
      if (k == 2 && slot_q[1].late && !slot_q[1].rdy) begin
        slot_d[k].rdy  = 1'b1;
        slot_d[k].data = mem_result;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int k = 0; k < PIPE_DEPTH; k++) slot_q[k] <= '0;
      wb_we_q   <= 1'b0;
      wb_rd_q   <= '0;
      wb_data_q <= '0;
    end else begin
      slot_q    <= slot_d;
      wb_we_q   <= slot_q[PIPE_DEPTH-1].valid;
      wb_rd_q   <= slot_q[PIPE_DEPTH-1].rd;
      wb_data_q <= slot_q[PIPE_DEPTH-1].data;
    end
  end

  // Out-of-range destinations are tracked in the slots but set no busy bit.
  always_comb begin
    busy_vec = '0;
    for (int k = 0; k < PIPE_DEPTH; k++) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (slot_q[k].valid && slot_q[k].rd == ENC_W'(r)) busy_vec[r] = 1'b1;
      end
    end
  end

  assign wb_we   = wb_we_q;
  assign wb_rd   = wb_rd_q;
  assign wb_data = wb_data_q;

endmodule

// File: tb/tb_pipe_scoreboard.sv
// Bench for pipe_scoreboard: directed scenarios plus a randomized run checked
// against an age-based model of in-flight writes. A second instance built with
// FWD_EN=0 shares the stimulus and is checked only in the legacy scenario.
module tb_pipe_scoreboard;

  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 4;
  localparam int ENC_W    = 2;
  localparam int PD       = 3;
  localparam int SRC_W    = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  logic                flush, id_valid, id_use_rs1, id_use_rs2, id_we, id_late;
  logic [ENC_W-1:0]    id_rs1, id_rs2, id_rd;
  logic [DATA_W-1:0]   rf_val1, rf_val2, ex_result, mem_result;

  logic                stall, wb_we;
  logic [DATA_W-1:0]   op_val1, op_val2, wb_data;
  logic [SRC_W-1:0]    fwd_src1, fwd_src2;
  logic [NUM_REGS-1:0] busy_vec;
  logic [ENC_W-1:0]    wb_rd;

  logic                leg_stall, leg_wb_we;
  logic [DATA_W-1:0]   leg_op_val1, leg_op_val2, leg_wb_data;
  logic [SRC_W-1:0]    leg_fwd_src1, leg_fwd_src2;
  logic [NUM_REGS-1:0] leg_busy_vec;
  logic [ENC_W-1:0]    leg_wb_rd;

  pipe_scoreboard #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .ENC_W(ENC_W), .PIPE_DEPTH(PD), .FWD_EN(1)) u_dut (
    .clk(clk), .resetn(resetn), .flush(flush), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_rd(id_rd), .id_we(id_we), .id_late(id_late),
    .rf_val1(rf_val1), .rf_val2(rf_val2), .ex_result(ex_result), .mem_result(mem_result),
    .stall(stall), .op_val1(op_val1), .op_val2(op_val2), .fwd_src1(fwd_src1), .fwd_src2(fwd_src2),
    .busy_vec(busy_vec), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data)
  );

  pipe_scoreboard #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .ENC_W(ENC_W), .PIPE_DEPTH(PD), .FWD_EN(0)) u_leg (
    .clk(clk), .resetn(resetn), .flush(flush), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_rd(id_rd), .id_we(id_we), .id_late(id_late),
    .rf_val1(rf_val1), .rf_val2(rf_val2), .ex_result(ex_result), .mem_result(mem_result),
    .stall(leg_stall), .op_val1(leg_op_val1), .op_val2(leg_op_val2),
    .fwd_src1(leg_fwd_src1), .fwd_src2(leg_fwd_src2),
    .busy_vec(leg_busy_vec), .wb_we(leg_wb_we), .wb_rd(leg_wb_rd), .wb_data(leg_wb_data)
  );

  int pass_cnt = 0;
  int total_cnt = 0;

  // ---------------- reference model state ----------------
  typedef struct {
    int                age;   // edges since entering EX
    logic [ENC_W-1:0]  rd;
    bit                late;
    logic [DATA_W-1:0] data;
  } pend_t;

  pend_t             pend_q[$];
  logic [DATA_W-1:0] rf [NUM_REGS];

  // ---------------- driver tasks ----------------
  task automatic idle();
    flush = 1'b0; id_valid = 1'b0; id_rs1 = '0; id_rs2 = '0;
    id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; id_rd = '0; id_we = 1'b0; id_late = 1'b0;
  endtask

  task automatic issue(input logic [ENC_W-1:0] rd, input logic [ENC_W-1:0] rs1, input logic [ENC_W-1:0] rs2,
                       input logic u1, input logic u2, input logic we, input logic late);
    flush = 1'b0; id_valid = 1'b1; id_rd = rd; id_rs1 = rs1; id_rs2 = rs2;
    id_use_rs1 = u1; id_use_rs2 = u2; id_we = we; id_late = late;
  endtask

  task automatic apply_reset();
    idle();
    rf_val1 = '0; rf_val2 = '0; ex_result = $urandom; mem_result = $urandom;
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
  endtask

  // ---------------- model ----------------
  function automatic void model_lookup(input logic [ENC_W-1:0] rs, input logic use_rs,
                                       input logic [DATA_W-1:0] rfv,
                                       output logic [DATA_W-1:0] val, output int src, output bit haz);
    int best;
    best = -1;
    val = rfv; src = 0; haz = 0;
    if (!use_rs) return;
    foreach (pend_q[i])
      if (pend_q[i].age < PD && pend_q[i].rd == rs && (best < 0 || pend_q[i].age < pend_q[best].age))
        best = i;
    if (best < 0) return;
    src = pend_q[best].age + 1;
    if (pend_q[best].age == 0) begin
      val = ex_result;
      haz = pend_q[best].late;
    end else if (pend_q[best].age == 1 && pend_q[best].late) begin
      val = mem_result;
    end else begin
      val = pend_q[best].data;
    end
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    idle();
    resetn = 1'b0;
    rf_val1 = 32'hDEAD_BEEF; rf_val2 = 32'h1234_5678; ex_result = $urandom; mem_result = $urandom;
    @(negedge clk); #1;
    total_cnt++; if (stall !== 1'b0) $display("FAIL rst_stall: got %0b exp 0", stall); else pass_cnt++;
    total_cnt++; if (busy_vec !== 4'b0000) $display("FAIL rst_busy: got %b exp 0000", busy_vec); else pass_cnt++;
    total_cnt++; if (wb_we !== 1'b0) $display("FAIL rst_wb_we: got %0b exp 0", wb_we); else pass_cnt++;
    total_cnt++; if (wb_rd !== 2'd0) $display("FAIL rst_wb_rd: got %0d exp 0", wb_rd); else pass_cnt++;
    total_cnt++; if (wb_data !== 32'd0) $display("FAIL rst_wb_data: got %h exp 0", wb_data); else pass_cnt++;
    id_use_rs1 = 1'b1; id_use_rs2 = 1'b1; #1;
    total_cnt++; if (fwd_src1 !== 2'd0 || fwd_src2 !== 2'd0) $display("FAIL rst_fwd_src: got %0d/%0d exp 0/0", fwd_src1, fwd_src2); else pass_cnt++;
    total_cnt++; if (op_val1 !== 32'hDEAD_BEEF) $display("FAIL rst_op_val1: got %h exp deadbeef", op_val1); else pass_cnt++;
    total_cnt++; if (op_val2 !== 32'h1234_5678) $display("FAIL rst_op_val2: got %h exp 12345678", op_val2); else pass_cnt++;
    resetn = 1'b1;
  endtask

  task automatic test_fwd_back_to_back();
    apply_reset();
    @(negedge clk); rf_val1 = 32'd3; rf_val2 = 32'd3; issue(0, 0, 1, 1, 1, 1, 0); #1;  // ADD r0 = r0 + r1
    total_cnt++; if (stall !== 1'b0 || fwd_src1 !== 2'd0 || op_val1 !== 32'd3) $display("FAIL b2b_add_ops: got stall=%0b src=%0d val=%0d exp 0/0/3", stall, fwd_src1, op_val1); else pass_cnt++;
    @(negedge clk); issue(0, 0, 0, 1, 0, 1, 0); ex_result = 32'd6; #1;             // INC r0
    total_cnt++; if (stall !== 1'b0) $display("FAIL b2b_stall: got %0b exp 0", stall); else pass_cnt++;
    total_cnt++; if (fwd_src1 !== 2'd1 || op_val1 !== 32'd6) $display("FAIL b2b_fwd: got src=%0d val=%0d exp 1/6", fwd_src1, op_val1); else pass_cnt++;
    @(negedge clk); idle(); ex_result = 32'd7; #1;
    total_cnt++; if (wb_we !== 1'b0) $display("FAIL b2b_wb_early1: got %0b exp 0", wb_we); else pass_cnt++;
    @(negedge clk); ex_result = $urandom; #1;
    total_cnt++; if (wb_we !== 1'b0) $display("FAIL b2b_wb_early2: got %0b exp 0", wb_we); else pass_cnt++;
    @(negedge clk); #1;
    total_cnt++; if (wb_we !== 1'b1 || wb_rd !== 2'd0 || wb_data !== 32'd6) $display("FAIL b2b_wb_add: got we=%0b rd=%0d data=%0d exp 1/0/6", wb_we, wb_rd, wb_data); else pass_cnt++;
    @(negedge clk); #1;
    total_cnt++; if (wb_we !== 1'b1 || wb_data !== 32'd7) $display("FAIL b2b_wb_inc: got we=%0b data=%0d exp 1/7", wb_we, wb_data); else pass_cnt++;
  endtask

  task automatic test_late_stall();
    apply_reset();
    @(negedge clk); issue(1, 0, 0, 0, 0, 1, 1); #1;                                  // late load into r1
    total_cnt++; if (stall !== 1'b0) $display("FAIL late_issue_stall: got %0b exp 0", stall); else pass_cnt++;
    @(negedge clk); issue(0, 1, 0, 1, 0, 0, 0); rf_val1 = 32'h77; #1;              // consumer of r1
    total_cnt++; if (stall !== 1'b1) $display("FAIL late_stall_on: got %0b exp 1", stall); else pass_cnt++;
    total_cnt++; if (busy_vec !== 4'b0010) $display("FAIL late_busy_ex: got %b exp 0010", busy_vec); else pass_cnt++;
    @(negedge clk); mem_result = 32'h5A; #1;
    total_cnt++; if (stall !== 1'b0) $display("FAIL late_stall_off: got %0b exp 0", stall); else pass_cnt++;
    total_cnt++; if (fwd_src1 !== 2'd2 || op_val1 !== 32'h5A) $display("FAIL late_fwd_mem: got src=%0d val=%h exp 2/5a", fwd_src1, op_val1); else pass_cnt++;
    @(negedge clk); idle(); mem_result = $urandom; #1;
    total_cnt++; if (busy_vec !== 4'b0010 || wb_we !== 1'b0) $display("FAIL late_busy_wb: got busy=%b we=%0b exp 0010/0", busy_vec, wb_we); else pass_cnt++;
    @(negedge clk); #1;
    total_cnt++; if (busy_vec !== 4'b0000) $display("FAIL late_busy_clear: got %b exp 0000", busy_vec); else pass_cnt++;
    total_cnt++; if (wb_we !== 1'b1 || wb_rd !== 2'd1 || wb_data !== 32'h5A) $display("FAIL late_wb: got we=%0b rd=%0d data=%h exp 1/1/5a", wb_we, wb_rd, wb_data); else pass_cnt++;
  endtask

  task automatic test_legacy_stall();
    int   stall_n;
    logic main_stall;
    logic [SRC_W-1:0]  main_src;
    logic [DATA_W-1:0] main_val;
    apply_reset();
    main_stall = 1'bx; main_src = 'x; main_val = 'x;
    @(negedge clk); issue(1, 0, 0, 0, 0, 1, 0); #1;                                  // ADD r1
    total_cnt++; if (leg_stall !== 1'b0) $display("FAIL leg_issue_stall: got %0b exp 0", leg_stall); else pass_cnt++;
    @(negedge clk); issue(0, 0, 1, 0, 1, 0, 0); ex_result = 32'h11; rf_val2 = 32'h3;
    stall_n = 0;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) begin
        @(negedge clk);
        ex_result = $urandom;
      end
      if (i >= 3) rf_val2 = 32'h11;  // register file holds the written value from here on
      #1;
      if (i == 0) begin
        main_stall = stall; main_src = fwd_src2; main_val = op_val2;
      end
      if (!leg_stall) break;
      stall_n++;
    end
    total_cnt++; if (stall_n !== 3) $display("FAIL leg_stall_len: got %0d exp 3", stall_n); else pass_cnt++;
    total_cnt++; if (leg_op_val2 !== 32'h11 || leg_fwd_src2 !== 2'd0) $display("FAIL leg_operand: got val=%h src=%0d exp 11/0", leg_op_val2, leg_fwd_src2); else pass_cnt++;
    total_cnt++; if (leg_wb_we !== 1'b1 || leg_wb_rd !== 2'd1 || leg_wb_data !== 32'h11) $display("FAIL leg_wb: got we=%0b rd=%0d data=%h exp 1/1/11", leg_wb_we, leg_wb_rd, leg_wb_data); else pass_cnt++;
    total_cnt++; if (main_stall !== 1'b0 || main_src !== 2'd1 || main_val !== 32'h11) $display("FAIL leg_vs_fwd: got stall=%0b src=%0d val=%h exp 0/1/11", main_stall, main_src, main_val); else pass_cnt++;
  endtask

  task automatic test_youngest_wins();
    apply_reset();
    @(negedge clk); issue(0, 0, 0, 0, 0, 1, 0); #1;                                  // r0 <- 4
    @(negedge clk); issue(2, 0, 0, 0, 0, 1, 0); ex_result = 32'd4; #1;              // r2 <- 0x22
    @(negedge clk); issue(0, 0, 0, 0, 0, 1, 0); ex_result = 32'h22; #1;             // r0 <- 9
    @(negedge clk); issue(3, 0, 2, 1, 1, 0, 0); ex_result = 32'd9; #1;
    total_cnt++; if (fwd_src1 !== 2'd1 || op_val1 !== 32'd9) $display("FAIL yw_rs1: got src=%0d val=%0d exp 1/9", fwd_src1, op_val1); else pass_cnt++;
    total_cnt++; if (fwd_src2 !== 2'd2 || op_val2 !== 32'h22) $display("FAIL yw_rs2: got src=%0d val=%h exp 2/22", fwd_src2, op_val2); else pass_cnt++;
    total_cnt++; if (busy_vec !== 4'b0101 || stall !== 1'b0) $display("FAIL yw_busy: got busy=%b stall=%0b exp 0101/0", busy_vec, stall); else pass_cnt++;
    @(negedge clk); issue(3, 0, 0, 1, 1, 0, 0); ex_result = $urandom; #1;
    total_cnt++; if (fwd_src1 !== 2'd2 || op_val1 !== 32'd9 || fwd_src2 !== 2'd2 || op_val2 !== 32'd9) $display("FAIL yw_same_src: got %0d/%0d %0d/%0d exp 2/9 2/9", fwd_src1, op_val1, fwd_src2, op_val2); else pass_cnt++;
    total_cnt++; if (wb_we !== 1'b1 || wb_rd !== 2'd0 || wb_data !== 32'd4) $display("FAIL yw_wb: got we=%0b rd=%0d data=%0d exp 1/0/4", wb_we, wb_rd, wb_data); else pass_cnt++;
  endtask

  task automatic test_flush();
    apply_reset();
    @(negedge clk); issue(3, 0, 0, 0, 0, 1, 1); #1;                                  // late writer of r3
    @(negedge clk); issue(0, 3, 0, 1, 0, 1, 0); flush = 1'b1; #1;
    total_cnt++; if (stall !== 1'b0) $display("FAIL flush_stall: got %0b exp 0", stall); else pass_cnt++;
    total_cnt++; if (busy_vec !== 4'b1000) $display("FAIL flush_busy_before: got %b exp 1000", busy_vec); else pass_cnt++;
    @(negedge clk); idle(); #1;
    total_cnt++; if (busy_vec !== 4'b0000) $display("FAIL flush_busy_after: got %b exp 0000", busy_vec); else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      total_cnt++; if (wb_we !== 1'b0) $display("FAIL flush_no_wb[%0d]: got %0b exp 0", i, wb_we); else pass_cnt++;
    end
  endtask

  task automatic test_reset_midstream();
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); issue(ENC_W'(i), 0, 0, 0, 0, 1, (i == 3)); ex_result = $urandom;
    end
    @(negedge clk); issue(0, 3, 0, 1, 0, 0, 0); #1;
    total_cnt++; if (stall !== 1'b1 || wb_we !== 1'b1 || busy_vec !== 4'b1110) $display("FAIL mid_before: got stall=%0b we=%0b busy=%b exp 1/1/1110", stall, wb_we, busy_vec); else pass_cnt++;
    #2 resetn = 1'b0; #1;
    total_cnt++; if (stall !== 1'b0 || wb_we !== 1'b0 || busy_vec !== 4'b0000) $display("FAIL mid_async: got stall=%0b we=%0b busy=%b exp 0/0/0000", stall, wb_we, busy_vec); else pass_cnt++;
    @(negedge clk); idle(); resetn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      total_cnt++; if (wb_we !== 1'b0) $display("FAIL mid_no_wb[%0d]: got %0b exp 0", i, wb_we); else pass_cnt++;
    end
  endtask

  task automatic test_random();
    logic [DATA_W-1:0]   ev1, ev2, exp_data;
    logic [NUM_REGS-1:0] exp_busy;
    logic [ENC_W-1:0]    exp_rd;
    int                  es1, es2;
    bit                  h1, h2, exp_stall, exp_we, hold;
    pend_t               ne;
    apply_reset();
    pend_q.delete();
    for (int r = 0; r < NUM_REGS; r++) rf[r] = $urandom;
    hold = 0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      @(negedge clk);
      if (!hold) begin
        id_valid   = ($urandom_range(0, 3) != 0);
        id_rs1     = ENC_W'($urandom_range(0, NUM_REGS - 1));
        id_rs2     = ENC_W'($urandom_range(0, NUM_REGS - 1));
        id_use_rs1 = ($urandom_range(0, 3) != 0);
        id_use_rs2 = ($urandom_range(0, 1) != 0);
        id_rd      = ENC_W'($urandom_range(0, NUM_REGS - 1));
        id_we      = ($urandom_range(0, 3) != 0);
        id_late    = ($urandom_range(0, 2) == 0);
      end
      flush      = ($urandom_range(0, 9) == 0);
      ex_result  = $urandom;
      mem_result = $urandom;
      rf_val1    = rf[id_rs1];
      rf_val2    = rf[id_rs2];
      #1;
      model_lookup(id_rs1, id_use_rs1, rf_val1, ev1, es1, h1);
      model_lookup(id_rs2, id_use_rs2, rf_val2, ev2, es2, h2);
      exp_stall = id_valid && !flush && (h1 || h2);
      exp_busy = '0; exp_we = 0; exp_rd = '0; exp_data = '0;
      foreach (pend_q[i]) begin
        if (pend_q[i].age < PD) exp_busy[pend_q[i].rd] = 1'b1;
        if (pend_q[i].age == PD) begin
          exp_we = 1; exp_rd = pend_q[i].rd; exp_data = pend_q[i].data;
        end
      end
      total_cnt++; if (stall !== exp_stall) $display("FAIL rnd_stall cyc=%0d: got %0b exp %0b", cyc, stall, exp_stall); else pass_cnt++;
      total_cnt++; if (fwd_src1 !== SRC_W'(es1) || op_val1 !== ev1) $display("FAIL rnd_op1 cyc=%0d: got src=%0d val=%h exp %0d/%h", cyc, fwd_src1, op_val1, es1, ev1); else pass_cnt++;
      total_cnt++; if (fwd_src2 !== SRC_W'(es2) || op_val2 !== ev2) $display("FAIL rnd_op2 cyc=%0d: got src=%0d val=%h exp %0d/%h", cyc, fwd_src2, op_val2, es2, ev2); else pass_cnt++;
      total_cnt++; if (busy_vec !== exp_busy) $display("FAIL rnd_busy cyc=%0d: got %b exp %b", cyc, busy_vec, exp_busy); else pass_cnt++;
      total_cnt++; if (wb_we !== exp_we) $display("FAIL rnd_wb_we cyc=%0d: got %0b exp %0b", cyc, wb_we, exp_we); else pass_cnt++;
      if (exp_we) begin
        total_cnt++; if (wb_rd !== exp_rd || wb_data !== exp_data) $display("FAIL rnd_wb cyc=%0d: got rd=%0d data=%h exp %0d/%h", cyc, wb_rd, wb_data, exp_rd, exp_data); else pass_cnt++;
      end
      hold = exp_stall;
      @(posedge clk);
      for (int i = pend_q.size() - 1; i >= 0; i--) begin
        if (pend_q[i].age == 0 && flush) begin
          pend_q.delete(i);
          continue;
        end
        if (pend_q[i].age == 0 && !pend_q[i].late) pend_q[i].data = ex_result;
        if (pend_q[i].age == 1 && pend_q[i].late) pend_q[i].data = mem_result;
        pend_q[i].age = pend_q[i].age + 1;
        if (pend_q[i].age == PD) rf[pend_q[i].rd] = pend_q[i].data;
        if (pend_q[i].age > PD) pend_q.delete(i);
      end
      if (id_valid && id_we && !exp_stall && !flush) begin
        ne.age = 0; ne.rd = id_rd; ne.late = id_late; ne.data = '0;
        pend_q.push_back(ne);
      end
    end
    idle();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_fwd_back_to_back();
    test_late_stall();
    test_legacy_stall();
    test_youngest_wins();
    test_flush();
    test_reset_midstream();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed so far", pass_cnt, total_cnt);
    $fatal(1);
  end

endmodule
